// File: rtl/code_detector_if.sv
// Bus between a sample source and the code detector: the sample stream and burst
// window in one direction, the chip decisions and correlation results in the other.
interface code_detector_if #(
  parameter int unsigned NB_INPUT = 16,
  parameter int unsigned CODE_LEN = 13
);
  localparam int unsigned MatchW = $clog2(CODE_LEN + 1);

  logic signed [NB_INPUT-1:0] data_in;
  logic                       data_valid;
  logic                       sinc;
  logic                       bit_out;
  logic                       bit_valid;
  logic [CODE_LEN-1:0]        code_reg;
  logic [MatchW-1:0]          match_count;
  logic                       detect;
  logic                       done;
  logic                       abort;
  logic                       busy;

  modport master (
    output data_in, data_valid, sinc,
    input  bit_out, bit_valid, code_reg, match_count, detect, done, abort, busy
  );

  modport slave (
    input  data_in, data_valid, sinc,
    output bit_out, bit_valid, code_reg, match_count, detect, done, abort, busy
  );
endinterface

// File: rtl/code_detector.sv
// Spread-code detector: integrates SAMPLES_PER_CHIP valid samples into a hard chip
// decision, shifts CODE_LEN chips into code_reg and correlates them against
// CODE_PATTERN once the burst is complete.
module code_detector #(
  parameter int unsigned         NB_INPUT         = 16,
  parameter int unsigned         SAMPLES_PER_CHIP = 8,
  parameter int unsigned         CODE_LEN         = 13,
  parameter logic [CODE_LEN-1:0] CODE_PATTERN     = 13'b1111100110101,
  parameter int unsigned         THRESHOLD        = 13
) (
  input logic             clk,
  input logic             rst,
  code_detector_if.slave  bus
);

  localparam int unsigned AccW   = NB_INPUT + $clog2(SAMPLES_PER_CHIP);
  localparam int unsigned SampW  = $clog2(SAMPLES_PER_CHIP);
  localparam int unsigned ChipW  = $clog2(CODE_LEN + 1);
  localparam int unsigned MatchW = $clog2(CODE_LEN + 1);

  typedef enum logic [1:0] {StIdle, StAccum, StCorr} state_e;

  state_e                   state_q;
  logic signed [AccW-1:0]   acc_q;
  logic [SampW-1:0]         samp_cnt_q;
  logic [ChipW-1:0]         chip_cnt_q;
  logic                     bit_out_q;
  logic                     bit_valid_q;
  logic [CODE_LEN-1:0]      code_reg_q;
  logic [MatchW-1:0]        match_q;
  logic                     detect_q;
  logic                     done_q;
  logic                     abort_q;

  logic signed [AccW-1:0]   sample_ext;
  logic signed [AccW-1:0]   sum;
  logic                     decision;
  logic [MatchW-1:0]        match_next;

  // Running chip sum including the current sample; a zero sum decides 0.
  always_comb begin
    sample_ext = AccW'(bus.data_in);
    sum        = acc_q + sample_ext;
    decision   = !sum[AccW-1] && (sum != '0);
  end

  // Count chip positions where the received word agrees with the pattern.
  always_comb begin
    match_next = '0;
    for (int i = 0; i < int'(CODE_LEN); i++) begin
      if (code_reg_q[i] == CODE_PATTERN[i]) match_next = match_next + MatchW'(1);
    end
  end

  // Burst FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      samp_cnt_q  <= '0;
      chip_cnt_q  <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      code_reg_q  <= '0;
      match_q     <= '0;
      detect_q    <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      bit_valid_q <= 1'b0;
      detect_q    <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // The opening sample is already the first sample of chip 0.
          if (bus.sinc && bus.data_valid) begin
            state_q    <= StAccum;
            acc_q      <= sample_ext;
            samp_cnt_q <= SampW'(1);
            chip_cnt_q <= '0;
            code_reg_q <= '0;
          end
        end
        StAccum: begin
          if (!bus.sinc) begin
            state_q    <= StIdle;
            abort_q    <= 1'b1;
            acc_q      <= '0;
            samp_cnt_q <= '0;
            chip_cnt_q <= '0;
          end else if (bus.data_valid) begin
            if (samp_cnt_q == SampW'(SAMPLES_PER_CHIP - 1)) begin
              bit_valid_q <= 1'b1;
              bit_out_q   <= decision;
              code_reg_q  <= {code_reg_q[CODE_LEN-2:0], decision};
              acc_q       <= '0;
              samp_cnt_q  <= '0;
              if (chip_cnt_q == ChipW'(CODE_LEN - 1)) begin
                chip_cnt_q <= '0;
                state_q    <= StCorr;
              end else begin
                chip_cnt_q <= chip_cnt_q + ChipW'(1);
              end
            end else begin
              acc_q      <= sum;
              samp_cnt_q <= samp_cnt_q + SampW'(1);
            end
          end
        end
        StCorr: begin
          // sinc is deliberately ignored here; a new burst can only open from idle.
          match_q  <= match_next;
          detect_q <= (match_next >= MatchW'(THRESHOLD));
          done_q   <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.bit_out     = bit_out_q;
  assign bus.bit_valid   = bit_valid_q;
  assign bus.code_reg    = code_reg_q;
  assign bus.match_count = match_q;
  assign bus.detect      = detect_q;
  assign bus.done        = done_q;
  assign bus.abort       = abort_q;
  assign bus.busy        = (state_q != StIdle);

endmodule

// File: tb/tb_code_detector.sv
// Bench for code_detector: two instances (THRESHOLD 13 and 12) share one stimulus
// stream; expected events are queued by the driver and popped by a negedge monitor.
module tb_code_detector;
  localparam int unsigned NB  = 16;
  localparam int unsigned SPC = 4;
  localparam int unsigned CL  = 13;
  localparam logic [12:0] PAT = 13'b1111100110101;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [15:0] d = '0;
  logic v = 1'b0;
  logic s = 1'b0;

  always #5 clk = ~clk;

  code_detector_if #(.NB_INPUT(NB), .CODE_LEN(CL)) ifa ();
  code_detector_if #(.NB_INPUT(NB), .CODE_LEN(CL)) ifb ();

  assign ifa.data_in = d;
  assign ifa.data_valid = v;
  assign ifa.sinc = s;
  assign ifb.data_in = d;
  assign ifb.data_valid = v;
  assign ifb.sinc = s;

  code_detector #(
    .NB_INPUT(NB), .SAMPLES_PER_CHIP(SPC), .CODE_LEN(CL), .CODE_PATTERN(PAT), .THRESHOLD(13)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );

  code_detector #(
    .NB_INPUT(NB), .SAMPLES_PER_CHIP(SPC), .CODE_LEN(CL), .CODE_PATTERN(PAT), .THRESHOLD(12)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic b;
    int   cyc;
  } bit_exp_t;

  typedef struct {
    bit          is_abort;
    logic [12:0] code;
    int          mc;
    bit          det;
    int          cyc;
  } end_exp_t;

  bit_exp_t bq[$];
  end_exp_t qa[$];
  end_exp_t qb[$];
  int mc_a = 0;
  int mc_b = 0;

  logic signed [15:0] zero_tbl [4] = '{16'sd100, -16'sd100, 16'sd50, -16'sd50};

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void check_end(input bit sel, input logic done, input logic abort,
                                    input logic det, input logic [12:0] code,
                                    input logic [3:0] mc);
    end_exp_t e;
    if (sel ? (qb.size() == 0) : (qa.size() == 0)) begin
      check(sel ? "B unexpected done/abort" : "A unexpected done/abort", 32'(done | abort), 0);
      return;
    end
    e = sel ? qb.pop_front() : qa.pop_front();
    check(sel ? "B abort" : "A abort", 32'(abort), 32'(e.is_abort));
    check(sel ? "B done" : "A done", 32'(done), 32'(!e.is_abort));
    check(sel ? "B detect" : "A detect", 32'(det), 32'(e.det));
    check(sel ? "B code_reg" : "A code_reg", 32'(code), 32'(e.code));
    check(sel ? "B match_count" : "A match_count", 32'(mc), 32'(e.mc));
    check(sel ? "B end cycle" : "A end cycle", cyc, e.cyc);
  endfunction

  // Monitor: compare whatever the DUTs present against the queued expectations.
  always @(negedge clk) begin
    bit_exp_t be;
    if (ifa.bit_valid === 1'b1) begin
      if (bq.size() == 0) begin
        check("unexpected bit_valid", 1, 0);
      end else begin
        be = bq.pop_front();
        check("bit_out", 32'(ifa.bit_out), 32'(be.b));
        check("bit_valid cycle", cyc, be.cyc);
      end
    end
    if (ifa.done === 1'b1 || ifa.abort === 1'b1)
      check_end(1'b0, ifa.done, ifa.abort, ifa.detect, ifa.code_reg, ifa.match_count);
    else if (ifa.detect === 1'b1) check("A stray detect", 1, 0);
    if (ifb.done === 1'b1 || ifb.abort === 1'b1)
      check_end(1'b1, ifb.done, ifb.abort, ifb.detect, ifb.code_reg, ifb.match_count);
    else if (ifb.detect === 1'b1) check("B stray detect", 1, 0);
  end

  task automatic drive(input logic signed [15:0] dd, input bit vv, input bit ss, input bit rr);
    @(posedge clk);
    #1;
    d = dd;
    v = vv;
    s = ss;
    rst = rr;
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk);
    check({tag, " A outputs"}, {ifa.bit_out, ifa.bit_valid, ifa.detect, ifa.done, ifa.abort,
                                ifa.busy, ifa.match_count, ifa.code_reg}, 0);
    check({tag, " B outputs"}, {ifb.bit_out, ifb.bit_valid, ifb.detect, ifb.done, ifb.abort,
                                ifb.busy, ifb.match_count, ifb.code_reg}, 0);
  endtask

  // One burst of decided chips rx (MSB first). exp_mc is the hand-computed match count.
  task automatic burst(input logic [12:0] rx, input int exp_mc, input bit gapped,
                       input int zero_chip, input int abort_chip, input bit rst_in_corr);
    logic signed [15:0] val;
    int last = 0;
    for (int c = 0; c < 13; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (c == abort_chip && k == 2) begin
          drive(16'sh7FFF, 1'b1, 1'b0, 1'b0);
          qa.push_back('{1'b1, rx >> (13 - c), mc_a, 1'b0, cyc + 1});
          qb.push_back('{1'b1, rx >> (13 - c), mc_b, 1'b0, cyc + 1});
          repeat (3) drive(16'sh0, 1'b0, 1'b0, 1'b0);
          return;
        end
        if (c == zero_chip) val = zero_tbl[k];
        else val = rx[12-c] ? 16'sh7FFF : 16'sh8000;
        drive(val, 1'b1, 1'b1, 1'b0);
        if (k == 3) begin
          bq.push_back('{rx[12-c], cyc + 1});
          last = cyc;
        end
        if (gapped) drive(16'sh5555, 1'b0, 1'b1, 1'b0);
      end
    end
    if (!rst_in_corr) begin
      mc_a = exp_mc;
      mc_b = exp_mc;
      qa.push_back('{1'b0, rx, exp_mc, exp_mc >= 13, last + 2});
      qb.push_back('{1'b0, rx, exp_mc, exp_mc >= 12, last + 2});
    end
    // CORR cycle: sinc and a valid sample here must be ignored.
    if (!gapped) drive(16'sh7FFF, 1'b1, 1'b1, rst_in_corr);
    if (rst_in_corr) begin
      drive(16'sh0, 1'b0, 1'b0, 1'b0);
      check_zero("reset in CORR");
      mc_a = 0;
      mc_b = 0;
    end
    repeat (3) drive(16'sh0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (3) drive(16'sh0, 1'b0, 1'b0, 1'b1);
    drive(16'sh0, 1'b0, 1'b0, 1'b0);
    check_zero("after reset");

    burst(PAT, 13, 1'b0, -1, -1, 1'b0);             // ideal
    burst(PAT ^ 13'h040, 12, 1'b0, -1, -1, 1'b0);   // chip 6 inverted
    burst(PAT, 13, 1'b1, -1, -1, 1'b0);             // data_valid every other cycle
    burst(PAT & ~13'h400, 12, 1'b0, 2, -1, 1'b0);   // chip 2 sums to zero -> 0
    burst(PAT, 13, 1'b0, -1, 5, 1'b0);              // sinc dropped in chip 5
    burst(PAT, 13, 1'b0, -1, -1, 1'b0);             // recovery burst

    // Reset in the middle of chip 1.
    for (int k = 0; k < 6; k++) begin
      drive(16'sh7FFF, 1'b1, 1'b1, 1'b0);
      if (k == 3) bq.push_back('{1'b1, cyc + 1});
    end
    drive(16'sh7FFF, 1'b1, 1'b1, 1'b1);
    drive(16'sh0, 1'b0, 1'b0, 1'b0);
    check_zero("reset mid-chip");
    mc_a = 0;
    mc_b = 0;

    burst(PAT, 13, 1'b0, -1, -1, 1'b1);             // reset during CORR
    burst(PAT ^ 13'h040, 12, 1'b0, -1, -1, 1'b0);

    repeat (4) drive(16'sh0, 1'b0, 1'b0, 1'b0);
    check("bit queue drained", bq.size(), 0);
    check("A end queue drained", qa.size(), 0);
    check("B end queue drained", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/code_detector.md
CODE_DETECTOR -- requirements
Module: code_detector

Interface
REQ-001 Parameter NB_INPUT, default 16: width of the signed input sample.
REQ-002 Parameter SAMPLES_PER_CHIP, default 8: valid samples integrated per chip, minimum 2.
REQ-003 Parameter CODE_LEN, default 13: chips per code word.
REQ-004 Parameter CODE_PATTERN, default 13'b1111100110101: expected chip sequence; the first-received chip is compared against the MSB.
REQ-005 Parameter THRESHOLD, default 13: minimum matching chips for detection, range 1..CODE_LEN.
REQ-006 Port clk, input, 1: single clock; all logic is rising-edge.
REQ-007 Port rst, input, 1: synchronous, active-high reset.
REQ-008 Port data_in, input, NB_INPUT: signed two's-complement received sample.
REQ-009 Port data_valid, input, 1: data_in is valid this cycle.
REQ-010 Port sinc, input, 1: code window; high for the whole coded burst.
REQ-011 Port bit_out, output, 1: decided chip value.
REQ-012 Port bit_valid, output, 1: one-cycle strobe qualifying bit_out.
REQ-013 Port code_reg, output, CODE_LEN: chips received in the current or last burst, newest in the LSB.
REQ-014 Port match_count, output, clog2(CODE_LEN+1): chips of code_reg equal to CODE_PATTERN.
REQ-015 Port detect, output, 1: one-cycle pulse, match_count >= THRESHOLD.
REQ-016 Port done, output, 1: one-cycle pulse, correlation finished (with or without detect).
REQ-017 Port abort, output, 1: one-cycle pulse, burst terminated early.
REQ-018 Port busy, output, 1: high in ACCUM and CORR states.

Function
REQ-019 The FSM SHALL have states IDLE, ACCUM and CORR.
REQ-020 IDLE->ACCUM SHALL occur on a cycle with sinc=1 and data_valid=1; that sample SHALL be the first sample of chip 0.
REQ-021 In ACCUM the block SHALL add each sample with data_valid=1 and sinc=1 to a signed accumulator of NB_INPUT+clog2(SAMPLES_PER_CHIP) bits, with no overflow or saturation.
REQ-022 Cycles with data_valid=0 SHALL neither add to the accumulator nor advance the sample counter.
REQ-023 On the SAMPLES_PER_CHIP-th sample, the decision SHALL be bit = 1 if sum > 0, else 0 (a zero sum decides 0).
REQ-024 In the cycle after the last sample: bit_valid=1, bit_out=decision, code_reg={code_reg[CODE_LEN-2:0],bit}, accumulator and sample counter cleared, chip counter incremented.
REQ-025 If the chip counter reaches CODE_LEN, the FSM SHALL go to CORR; otherwise it SHALL stay in ACCUM, and the next valid sample starts the next chip with no gap cycle.
REQ-026 CORR SHALL last exactly one cycle; on its following cycle match_count SHALL be updated, done=1, detect=(match_count>=THRESHOLD), state=IDLE.
REQ-027 Latency SHALL be: last sample at cycle t -> final bit_valid at t+1 -> done/detect at t+2.
REQ-028 sinc=0 while in ACCUM SHALL discard the partial chip and chip counter, pulse abort next cycle, go to IDLE, and leave code_reg and match_count unchanged except for chips already shifted in.
REQ-029 sinc in CORR SHALL be ignored; a new burst SHALL start only from IDLE, the earliest being the cycle after done.
REQ-030 code_reg SHALL be cleared to 0 when a new burst starts (IDLE->ACCUM).
REQ-031 match_count, code_reg and bit_out SHALL hold their values between updates; bit_valid, detect, done and abort SHALL be single-cycle pulses.

Reset
REQ-032 With rst=1 at a clock edge, state SHALL be IDLE and every output, the accumulator and all counters SHALL be 0 on the next cycle, regardless of the current state.
REQ-033 rst SHALL take precedence over sinc and data_valid; no pulse SHALL be emitted for a burst interrupted by reset.

Verification (NB_INPUT=16, SAMPLES_PER_CHIP=4, CODE_LEN=13, default pattern, THRESHOLD=13)
REQ-034 Ideal burst: 52 continuous valid samples, chip 1 -> 0x7FFF x4, chip 0 -> 0x8000 x4, following 1111100110101 -> 13 bit_valid pulses, code_reg=13'h1F35, match_count=13, detect=1 and done=1 two cycles after the last sample.
REQ-035 One chip inverted (chip 6) with THRESHOLD=12 -> match_count=12, detect=1; same stimulus with THRESHOLD=13 -> done=1, detect=0.
REQ-036 data_valid toggled every other cycle during the burst -> same results as REQ-034, with bit_valid every 8 cycles.
REQ-037 Chip whose samples sum to 0 (+100,-100,+50,-50) -> bit_out=0.
REQ-038 sinc dropped after 2 samples of chip 5 -> abort=1, state IDLE, code_reg=5 bits shifted, no done and no detect; a new burst then decodes correctly.
REQ-039 rst=1 asserted mid-chip and mid-CORR -> all outputs 0 next cycle, no done or detect pulse.
